pdp_bus_arbiter: RTL
====================

Name: pdp_bus_arbiter

Overview:
- Two-master arbiter for the shared unibus-style memory/IO bus.
- Masters: CPU (M0) and disk DMA engine (M1, RK controller).
- Serialises one transaction at a time onto the shared bus and routes ack, error and read data back to the owning master.
- Bus timeout (NXM) and DMA burst-limit fairness are handled here.

Parameters:
- TIMEOUT, 64: cycles without bus_ack/bus_error before the arbiter aborts with error; counter width is clog2(TIMEOUT+1).
- DMA_BURST, 4: max consecutive DMA grants while the CPU is waiting; the next grant then goes to the CPU.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_addr  in  22  CPU address.
- cpu_data_in  in  16  CPU write data.
- cpu_rd / cpu_wr  in  1 each  CPU request; held until cpu_ack or cpu_error.
- cpu_byte_op  in  1  CPU byte transfer.
- cpu_ack / cpu_error  out  1 each  one-cycle completion pulses to CPU.
- cpu_data_out  out  16  read data; valid in the cpu_ack cycle.
- dma_addr, dma_data_in, dma_rd, dma_wr, dma_byte_op  in  same as CPU  DMA master request.
- dma_ack, dma_error, dma_data_out  out  same as CPU  DMA completion.
- bus_addr  out  22  shared bus address.
- bus_data_in  out  16  shared bus write data.
- bus_rd / bus_wr / bus_byte_op  out  1 each  shared bus strobes.
- bus_data_out  in  16  slave read data.
- bus_ack / bus_error  in  1 each  slave completion.
- grant_dma  out  1  high while DMA owns the bus (debug/visibility).

Behaviour:
- Request: m_req = m_rd | m_wr. rd and wr together from one master is illegal; the arbiter treats it as a read.
- States: IDLE, CPU_XFER, DMA_XFER, DONE. Reset forces IDLE.
- Reset values: all outputs 0; burst counter 0; timeout counter 0.
- IDLE, decided at rising edge k:
  - dma_req only -> DMA_XFER.
  - cpu_req only -> CPU_XFER.
  - Both: DMA_XFER unless burst_cnt == DMA_BURST, then CPU_XFER.
  - Neither: stay in IDLE.
- Grant load, at edge k: the arbiter registers the owner's addr, data, rd, wr and byte_op into the bus output registers. bus_* are valid from edge k to the completion edge and stable throughout. The master must hold its inputs; changes after grant are ignored.
- Completion, at edge m, first edge with bus_ack or bus_error sampled high in an XFER state:
  - bus_* strobes clear to 0; addr and data hold their last value.
  - Owner's ack or error pulses high for exactly one cycle (m to m+1).
  - Owner's data_out latches bus_data_out on ack-reads; otherwise it holds.
  - State goes to DONE.
- bus_ack and bus_error together -> error only.
- DONE: lasts one cycle and ignores all requests, so the master can drop its request. Always returns to IDLE. Minimum spacing between grants is therefore 3 cycles.
- Timeout: the counter clears on grant and increments each XFER cycle. On reaching TIMEOUT with no ack or error, strobes clear, owner_error pulses, state -> DONE. A late bus_ack in DONE or IDLE is ignored.
- Burst count:
  - CPU grant, or a DMA grant with no cpu_req pending, -> burst_cnt = 0.
  - DMA grant with cpu_req pending -> burst_cnt + 1, saturating at DMA_BURST.
- Non-owner ack, error and data_out stay 0 or held; a master never sees another master's completion.
- Async reset mid-transfer: the state machine and all outputs return to reset values immediately, with no ack or error to either master.
- grant_dma = (state == DMA_XFER).

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, CPU_XFER=2'd1, DMA_XFER=2'd2, DONE=2'd3);
  - master index constants;
  - bus width defines (ADDR_W=22, DATA_W=16), shared with the bus and RK blocks.
- One natural sub-module, pdp_bus_timeout: loadable down-counter with clear and expire pulse, reused by the RK and IDE paths.
- The muxing and state machine stay in the top.

Test Plan:
- CPU write only: cpu_wr, addr 22'o000000, data 16'ha5a5; slave acks 2 cycles after grant.
  Required: bus_wr high 3 cycles, bus_data_in = a5a5, then one cpu_ack pulse; dma_ack stays 0.
- DMA read: memory at 22'o001000 = 16'h1234.
  Required: dma_data_out = 1234 in the dma_ack cycle; grant_dma high only during the transfer.
- Simultaneous CPU and DMA requests, both held continuously, DMA_BURST=4.
  Required grant order: D, D, D, D, C, D, D, D, D, C; spacing 3 cycles with an immediate ack.
- Unmapped address: no bus_ack.
  Required: error pulse exactly TIMEOUT=64 cycles after grant; strobes drop; next request is served normally; a late ack is ignored.
- bus_ack and bus_error asserted together on a CPU read.
  Required: cpu_error=1, cpu_ack=0, cpu_data_out unchanged.
- Reset asserted 1 cycle into DMA_XFER.
  Required: bus_rd and bus_wr 0 immediately, no dma_ack or dma_error, state IDLE; a subsequent CPU request is granted.

Source files
------------

// File: rtl/pdp_bus_arbiter_pkg.sv
// Shared definitions for the PDP bus arbiter: bus widths, master indices,
// arbiter state encoding and the per-master request bundle.
package pdp_bus_arbiter_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  localparam int MASTER_CPU = 0;
  localparam int MASTER_DMA = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_XFER = 2'd1,
    ST_DMA_XFER = 2'd2,
    ST_DONE     = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rd;
    logic              wr;
    logic              byte_op;
  } bus_req_t;

endpackage

// File: rtl/pdp_bus_timeout.sv
// Loadable down-counter: load on grant, count down while enabled, and pulse
// expire_o in the cycle whose clock edge would bring the count to zero.
module pdp_bus_timeout #(
  parameter int TIMEOUT = 64,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(TIMEOUT);
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pdp_bus_arbiter.sv
// Two-master (CPU, RK disk DMA) arbiter for the shared unibus-style bus:
// one transaction at a time, NXM timeout and DMA burst-limit fairness.
module pdp_bus_arbiter
  import pdp_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int DMA_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data_in,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic              cpu_byte_op,
  output logic              cpu_ack,
  output logic              cpu_error,
  output logic [DATA_W-1:0] cpu_data_out,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_data_in,
  input  logic              dma_rd,
  input  logic              dma_wr,
  input  logic              dma_byte_op,
  output logic              dma_ack,
  output logic              dma_error,
  output logic [DATA_W-1:0] dma_data_out,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data_in,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic              bus_byte_op,
  input  logic [DATA_W-1:0] bus_data_out,
  input  logic              bus_ack,
  input  logic              bus_error,
  output logic              grant_dma
);

  localparam int BURST_W = $clog2(DMA_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              bus_rd_q, bus_rd_d;
  logic              bus_wr_q, bus_wr_d;
  logic              bus_bop_q, bus_bop_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cpu_err_q, cpu_err_d;
  logic              dma_ack_q, dma_ack_d;
  logic              dma_err_q, dma_err_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic [DATA_W-1:0] dma_dout_q, dma_dout_d;

  bus_req_t req_a [2];
  bus_req_t win_req;
  logic     cpu_req, dma_req, burst_full, pick_dma;
  logic     grant_cpu_w, grant_dma_w, in_xfer, expire;
  logic     resp_ack, resp_err, xfer_done;

  assign req_a[MASTER_CPU] = '{addr: cpu_addr, data: cpu_data_in, rd: cpu_rd,
                               wr: cpu_wr, byte_op: cpu_byte_op};
  assign req_a[MASTER_DMA] = '{addr: dma_addr, data: dma_data_in, rd: dma_rd,
                               wr: dma_wr, byte_op: dma_byte_op};

  assign cpu_req    = cpu_rd | cpu_wr;
  assign dma_req    = dma_rd | dma_wr;
  assign burst_full = (burst_q == BURST_W'(DMA_BURST));
  // DMA wins ties until it has used its burst allowance against a waiting CPU.
  assign pick_dma    = dma_req && !(cpu_req && burst_full);
  assign grant_dma_w = (state_q == ST_IDLE) && pick_dma;
  assign grant_cpu_w = (state_q == ST_IDLE) && cpu_req && !pick_dma;
  assign win_req     = pick_dma ? req_a[MASTER_DMA] : req_a[MASTER_CPU];

  assign in_xfer   = (state_q == ST_CPU_XFER) || (state_q == ST_DMA_XFER);
  assign resp_err  = in_xfer && (bus_error || (expire && !bus_ack));
  assign resp_ack  = in_xfer && bus_ack && !bus_error;
  assign xfer_done = resp_ack || resp_err;

  pdp_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i    (clk),
    .rst_i    (reset),
    .load_i   (grant_cpu_w || grant_dma_w),
    .clr_i    (xfer_done),
    .en_i     (in_xfer),
    .expire_o (expire)
  );

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    bus_rd_d   = bus_rd_q;
    bus_wr_d   = bus_wr_q;
    bus_bop_d  = bus_bop_q;
    cpu_ack_d  = 1'b0;
    cpu_err_d  = 1'b0;
    dma_ack_d  = 1'b0;
    dma_err_d  = 1'b0;
    cpu_dout_d = cpu_dout_q;
    dma_dout_d = dma_dout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_dma_w || grant_cpu_w) begin
          state_d    = grant_dma_w ? ST_DMA_XFER : ST_CPU_XFER;
          bus_addr_d = win_req.addr;
          bus_data_d = win_req.data;
          // rd and wr together is illegal and is served as a read
          bus_rd_d   = win_req.rd;
          bus_wr_d   = win_req.wr && !win_req.rd;
          bus_bop_d  = win_req.byte_op;
          if (grant_dma_w && cpu_req) begin
            burst_d = burst_full ? burst_q : burst_q + 1'b1;
          end else begin
            burst_d = '0;
          end
        end
      end
      ST_CPU_XFER, ST_DMA_XFER: begin
        if (xfer_done) begin
          state_d   = ST_DONE;
          bus_rd_d  = 1'b0;
          bus_wr_d  = 1'b0;
          bus_bop_d = 1'b0;
          if (state_q == ST_CPU_XFER) begin
            cpu_ack_d = resp_ack;
            cpu_err_d = resp_err;
            if (resp_ack && bus_rd_q) cpu_dout_d = bus_data_out;
          end else begin
            dma_ack_d = resp_ack;
            dma_err_d = resp_err;
            if (resp_ack && bus_rd_q) dma_dout_d = bus_data_out;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      burst_q    <= '0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      bus_rd_q   <= 1'b0;
      bus_wr_q   <= 1'b0;
      bus_bop_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cpu_err_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
      dma_err_q  <= 1'b0;
      cpu_dout_q <= '0;
      dma_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      bus_rd_q   <= bus_rd_d;
      bus_wr_q   <= bus_wr_d;
      bus_bop_q  <= bus_bop_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_err_q  <= cpu_err_d;
      dma_ack_q  <= dma_ack_d;
      dma_err_q  <= dma_err_d;
      cpu_dout_q <= cpu_dout_d;
      dma_dout_q <= dma_dout_d;
    end
  end

  assign bus_addr     = bus_addr_q;
  assign bus_data_in  = bus_data_q;
  assign bus_rd       = bus_rd_q;
  assign bus_wr       = bus_wr_q;
  assign bus_byte_op  = bus_bop_q;
  assign cpu_ack      = cpu_ack_q;
  assign cpu_error    = cpu_err_q;
  assign cpu_data_out = cpu_dout_q;
  assign dma_ack      = dma_ack_q;
  assign dma_error    = dma_err_q;
  assign dma_data_out = dma_dout_q;
  assign grant_dma    = (state_q == ST_DMA_XFER);

endmodule
